// File: rtl/fib_pkg.sv
// Shared types, default sizes and a helper for the Fibonacci engine.
//   fib_state_e       : controller states
//   FIB_WIDTH, FIB_NW : default term width and index width
//   fib_max_n_no_ovf  : largest n whose F(n) fits in a given width
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_e;

    localparam int unsigned FIB_WIDTH = 16;
    localparam int unsigned FIB_NW    = 8;

    // Largest n with F(n) < 2**width. Widths above 62 are clamped.
    function automatic int unsigned fib_max_n_no_ovf(input int unsigned width);
        longint unsigned a;
        longint unsigned b;
        longint unsigned t;
        longint unsigned lim;
        int unsigned     n;
        int unsigned     w;
        w   = (width > 32'd62) ? 32'd62 : width;
        lim = 64'(1) << w;
        a   = 64'd0;
        b   = 64'd1;
        n   = 32'd0;
        // Invariant: a = F(n), b = F(n+1)
        while (b < lim) begin
            t = a + b;
            a = b;
            b = t;
            n = n + 32'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fib_seq_gen_step.sv
// Combinational next-term adder with the per-term overflow rule.
//   a_i, b_i       : current terms F(k), F(k+1)
//   ova_i, ovb_i   : overflow flags attached to a and b
//   sum_o_c        : (a + b) truncated to WIDTH bits
//   carry_o_c      : carry out of a + b
//   ovb_next_o_c   : overflow flag for the new b (sticky)
module fib_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ova_i,
    input  logic             ovb_i,
    output logic [WIDTH-1:0] sum_o_c,
    output logic             carry_o_c,
    output logic             ovb_next_o_c
);

    // Once any earlier term overflowed, every later term is flagged too.
    always_comb begin
        {carry_o_c, sum_o_c} = {1'b0, a_i} + {1'b0, b_i};
        ovb_next_o_c         = ova_i | ovb_i | carry_o_c;
    end

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci engine: on an accepted start computes F(n) at one term per cycle,
// flags overflow of the requested term, and optionally streams F(0)..F(n).
//   clk, rst_n       : clock, asynchronous active-low reset
//   start_i          : request, accepted only in IDLE
//   n_i, stream_en_i : index and stream mode, sampled on accepted start
//   busy_o, done_o   : busy in RUN/DONE; one-cycle result-valid pulse
//   fib_o, overflow_o: F(n) mod 2**WIDTH and its overflow flag, held
//   term_o, term_valid_o, term_ready_i : valid/ready term stream
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH = FIB_WIDTH,
    parameter int unsigned NW    = FIB_NW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [NW-1:0]    n_i,
    input  logic             stream_en_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] fib_o,
    output logic             overflow_o,
    output logic [WIDTH-1:0] term_o,
    output logic             term_valid_o,
    input  logic             term_ready_i
);

    fib_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [NW-1:0]    k_q, k_d;
    logic [NW-1:0]    n_lat_q, n_lat_d;
    logic             str_q, str_d;
    logic             ova_q, ova_d;
    logic             ovb_q, ovb_d;
    logic [WIDTH-1:0] fib_q, fib_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tvalid_q, tvalid_d;

    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    logic             ovb_next_c;
    logic             adv_c;

    fib_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i          (a_q),
        .b_i          (b_q),
        .ova_i        (ova_q),
        .ovb_i        (ovb_q),
        .sum_o_c      (sum_c),
        .carry_o_c    (carry_c),
        .ovb_next_o_c (ovb_next_c)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        n_lat_d = n_lat_q;
        str_d   = str_q;
        ova_d   = ova_q;
        ovb_d   = ovb_q;
        fib_d   = fib_q;
        ovf_d   = ovf_q;
        adv_c   = !str_q || term_ready_i;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    n_lat_d = n_i;
                    str_d   = stream_en_i;
                    a_d     = '0;
                    b_d     = WIDTH'(1);
                    k_d     = '0;
                    ova_d   = 1'b0;
                    ovb_d   = 1'b0;
                end
            end
            RUN: begin
                // In stream mode the current term must be accepted before moving on.
                if (adv_c) begin
                    if (k_q == n_lat_q) begin
                        fib_d   = a_q;
                        ovf_d   = ova_q;
                        state_d = DONE;
                    end else begin
                        a_d   = b_q;
                        b_d   = sum_c;
                        ova_d = ovb_q;
                        ovb_d = ovb_next_c;
                        k_d   = k_q + NW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags track the state being entered so they stay registered.
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        tvalid_d = (state_d == RUN) && str_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            n_lat_q  <= '0;
            str_q    <= 1'b0;
            ova_q    <= 1'b0;
            ovb_q    <= 1'b0;
            fib_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            n_lat_q  <= n_lat_d;
            str_q    <= str_d;
            ova_q    <= ova_d;
            ovb_q    <= ovb_d;
            fib_q    <= fib_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fib_o        = fib_q;
    assign overflow_o   = ovf_q;
    assign term_o       = a_q;
    assign term_valid_o = tvalid_q;

endmodule
